// File: rtl/sfifo_serial_tx.sv
// ============================================================================
// Module   : sfifo_serial_tx
// Brief    : Pops bytes from a synchronous FIFO and sends each one as an async
//            frame (start, DATA_WIDTH bits LSB first, optional parity, stop).
//            Define SFIFO_TX_PARITY_EN to insert an even-parity bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sfifo_serial_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_BITS     = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  tx_enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read_n,
  output logic                  tx_serial,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int                  c_IDX_BITS = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [c_IDX_BITS-1:0] c_LAST_IDX = c_IDX_BITS'(DATA_WIDTH - 1);
  localparam logic [CNT_BITS-1:0]   c_BAUD_LAST = CNT_BITS'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    WAIT   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
`ifdef SFIFO_TX_PARITY_EN
    PARITY = 3'd5,
`endif
    STOP   = 3'd6
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [CNT_BITS-1:0]     r_baud;
  logic [c_IDX_BITS-1:0]   r_bit_idx;
  logic [DATA_WIDTH-1:0]   r_shift;
  logic                    r_frame_done;
  logic                    w_bit_state;
  logic                    w_baud_end;
  logic                    w_can_start;
`ifdef SFIFO_TX_PARITY_EN
  logic                    r_parity;
`endif

  assign w_baud_end  = (r_baud == c_BAUD_LAST);
  assign w_can_start = tx_enable && !fifo_empty;

  always_comb begin
    w_bit_state = 1'b0;
    case (r_state)
      START, DATA, STOP: w_bit_state = 1'b1;
`ifdef SFIFO_TX_PARITY_EN
      PARITY:            w_bit_state = 1'b1;
`endif
      default:           w_bit_state = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    w_next_state = r_state;
    fifo_read_n  = 1'b1;
    tx_serial    = 1'b1;
    busy         = (r_state != IDLE);
    frame_done   = r_frame_done;
    case (r_state)
      IDLE: begin
        if (w_can_start) w_next_state = FETCH;
      end
      FETCH: begin
        fifo_read_n  = 1'b0;
        w_next_state = WAIT;
      end
      WAIT: begin
        w_next_state = START;
      end
      START: begin
        tx_serial = 1'b0;
        if (w_baud_end) w_next_state = DATA;
      end
      DATA: begin
        tx_serial = r_shift[0];
        if (w_baud_end && (r_bit_idx == c_LAST_IDX)) begin
`ifdef SFIFO_TX_PARITY_EN
          w_next_state = PARITY;
`else
          w_next_state = STOP;
`endif
        end
      end
`ifdef SFIFO_TX_PARITY_EN
      PARITY: begin
        tx_serial = r_parity;
        if (w_baud_end) w_next_state = STOP;
      end
`endif
      STOP: begin
        if (w_baud_end) w_next_state = w_can_start ? FETCH : IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Datapath: baud counter, bit index, shift register and frame_done pulse
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_baud       <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= (r_state == STOP) && w_baud_end;

      if (w_bit_state && !w_baud_end) begin
        r_baud <= r_baud + CNT_BITS'(1);
      end else begin
        r_baud <= '0;
      end

      if (r_state == DATA) begin
        if (w_baud_end) r_bit_idx <= r_bit_idx + c_IDX_BITS'(1);
      end else begin
        r_bit_idx <= '0;
      end

      if (r_state == WAIT) begin
        r_shift <= fifo_data;
      end else if ((r_state == DATA) && w_baud_end) begin
        r_shift <= {1'b0, r_shift[DATA_WIDTH-1:1]};
      end
    end
  end

`ifdef SFIFO_TX_PARITY_EN
  // Parity comes from the byte as captured, since r_shift is consumed while sending.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_parity <= 1'b0;
    end else if (r_state == WAIT) begin
      r_parity <= ^fifo_data;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sfifo_serial_tx.sv
// ============================================================================
// Module   : tb_sfifo_serial_tx
// Brief    : Scoreboard bench for sfifo_serial_tx with a queue-based FIFO model
//            and a per-cycle frame reference built from the frame format.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sfifo_serial_tx;

  localparam int CPB = 4;
`ifdef SFIFO_TX_PARITY_EN
  localparam int NSLOTS = 11;
`else
  localparam int NSLOTS = 10;
`endif
  localparam int FL = NSLOTS * CPB;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       tx_enable = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_read_n;
  logic       tx_serial;
  logic       busy;
  logic       frame_done;

  sfifo_serial_tx #(
    .DATA_WIDTH  (8),
    .CLKS_PER_BIT(CPB),
    .CNT_BITS    (16)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .tx_enable  (tx_enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_read_n(fifo_read_n),
    .tx_serial  (tx_serial),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  int         checks = 0;
  int         failures = 0;
  int         pops = 0;
  int         cyc_count = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         start_times[$];

  bit          in_frame = 1'b0;
  bit          expect_done = 1'b0;
  bit          busy_ok = 1'b1;
  int          fcyc = 0;
  logic [63:0] act_v = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Expected line level for cycle c of a frame carrying byte b
  function automatic logic exp_bit(input logic [7:0] b, input int c);
    int slot;
    slot = c / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if ((NSLOTS == 11) && (slot == 9)) return ^b;
    return 1'b1;
  endfunction

  function automatic logic [63:0] frame_vec(input logic [7:0] b);
    logic [63:0] v;
    v = '0;
    for (int c = 0; c < FL; c++) v[c] = exp_bit(b, c);
    return v;
  endfunction

  // Registered-output FIFO model
  always @(posedge clock) begin
    cyc_count <= cyc_count + 1;
    if ((fifo_read_n === 1'b0) && (fifo_q.size() > 0)) begin
      fifo_data <= fifo_q.pop_front();
      pops <= pops + 1;
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  // Monitor / scoreboard
  always @(negedge clock) begin
    if (fifo_read_n === 1'b0) check("pop_underflow", 64'(fifo_q.size() == 0), 64'd0);
    if (reset_n === 1'b0) begin
      if (in_frame && (exp_q.size() > 0)) void'(exp_q.pop_front());
      in_frame    = 1'b0;
      expect_done = 1'b0;
    end else begin
      if (expect_done) begin
        check("frame_done_pulse", 64'(frame_done), 64'd1);
        expect_done = 1'b0;
      end else if (frame_done !== 1'b0) begin
        check("frame_done_spurious", 64'(frame_done), 64'd0);
      end
      if (!in_frame && (tx_serial === 1'b0)) begin
        in_frame = 1'b1;
        fcyc     = 0;
        act_v    = '0;
        busy_ok  = 1'b1;
        start_times.push_back(cyc_count);
      end
      if (in_frame) begin
        act_v[fcyc] = tx_serial;
        if (busy !== 1'b1) busy_ok = 1'b0;
        fcyc++;
        if (fcyc == FL) begin
          in_frame    = 1'b0;
          expect_done = 1'b1;
          check("busy_in_frame", 64'(busy_ok), 64'd1);
          if (exp_q.size() == 0) begin
            check("unexpected_frame", act_v, 64'd0);
            if (act_v == 64'd0) check("unexpected_frame", 64'd1, 64'd0);
          end else begin
            check("frame_bits", act_v, frame_vec(exp_q.pop_front()));
          end
        end
      end
    end
  end

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!((busy === 1'b0) && !expect_done && !in_frame &&
                 (!tx_enable || (fifo_q.size() == 0))) && (n < maxc));
    if (n >= maxc) check("wait_idle_timeout", 64'(n), 64'(maxc - 1));
  endtask

  initial begin
    int p0;
    int n;
    bit low_seen;

    // Reset held with data available and enable high
    tx_enable = 1'b1;
    push(8'hA5);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check("rst_tx", 64'(tx_serial), 64'd1);
      check("rst_read_n", 64'(fifo_read_n), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
    end
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("first_read_low", 64'(fifo_read_n), 64'd0);
    @(posedge clock);
    #1;
    check("read_one_cycle", 64'(fifo_read_n), 64'd1);
    wait_idle(300);
    check("pops_single", 64'(pops), 64'd1);

    // Byte with odd ones count
    push(8'h07);
    wait_idle(300);
    check("pops_07", 64'(pops), 64'd2);

    // Back-to-back frames
    start_times.delete();
    push(8'h01);
    push(8'h80);
    push(8'hFF);
    wait_idle(600);
    check("pops_b2b", 64'(pops), 64'd5);
    check("b2b_frames", 64'(start_times.size()), 64'd3);
    if (start_times.size() == 3) begin
      check("b2b_gap_1", 64'(start_times[1] - start_times[0]), 64'(FL + 2));
      check("b2b_gap_2", 64'(start_times[2] - start_times[1]), 64'(FL + 2));
    end
    check("b2b_idle_busy", 64'(busy), 64'd0);

    // Empty FIFO with enable high
    p0 = pops;
    low_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clock);
      #1;
      if (tx_serial !== 1'b1) low_seen = 1'b1;
    end
    check("empty_no_pop", 64'(pops), 64'(p0));
    check("empty_line_high", 64'(low_seen), 64'd0);

    // Enable dropped mid-frame
    p0 = pops;
    for (int i = 0; i < 3; i++) push(8'($urandom));
    n = 0;
    while ((busy !== 1'b1) && (n < 20)) begin
      @(posedge clock);
      #1;
      n++;
    end
    repeat (10) @(posedge clock);
    #1;
    tx_enable = 1'b0;
    wait_idle(300);
    check("en_drop_pops", 64'(pops), 64'(p0 + 1));
    check("en_drop_left", 64'(fifo_q.size()), 64'd2);
    repeat (5) @(posedge clock);
    #1;
    check("en_drop_no_pop", 64'(pops), 64'(p0 + 1));
    tx_enable = 1'b1;
    wait_idle(600);
    check("en_resume_pops", 64'(pops), 64'(p0 + 3));

    // Reset during data bit 3
    p0 = pops;
    push(8'($urandom));
    push(8'($urandom));
    n = 0;
    while (!in_frame && (n < 20)) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("midrst_started", 64'(in_frame), 64'd1);
    repeat (16) @(posedge clock);
    #1;
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    check("midrst_tx", 64'(tx_serial), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    reset_n = 1'b1;
    wait_idle(300);
    check("midrst_pops", 64'(pops), 64'(p0 + 2));

    // Random bursts
    for (int r = 0; r < 4; r++) begin
      p0 = pops;
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) push(8'($urandom));
      wait_idle(800);
      check("rand_pops", 64'(pops), 64'(p0 + n));
    end

    repeat (3) @(posedge clock);
    #1;
    check("final_exp_empty", 64'(exp_q.size()), 64'd0);
    check("final_fifo_empty", 64'(fifo_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: time %0t, limit 200000", $time);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/sfifo_serial_tx.md
Name: sfifo_serial_tx

Overview:
- Drain-side consumer for the 8-bit synchronous FIFO (active-low read strobe, registered data_out, empty flag).
- Pops one byte at a time and serialises each byte as an asynchronous frame: start bit, 8 data bits LSB first, optional parity bit, stop bit.
- Sits between the FIFO read port and a UART-style output pin.

Parameters:
- DATA_WIDTH, 8: byte width; must equal the FIFO data width.
- CLKS_PER_BIT, 16: clock cycles per serial bit; legal range 2..65535.
- CNT_BITS, 16: width of the baud counter; must hold CLKS_PER_BIT-1.

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset_n  input  1  synchronous, active-low reset.
- tx_enable  input  1  permits starting a new frame; never aborts a frame in progress.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  DATA_WIDTH  FIFO registered read data.
- fifo_read_n  output  1  FIFO read strobe, active low.
- tx_serial  output  1  serial line; idles high.
- busy  output  1  high whenever the FSM is not in IDLE.
- frame_done  output  1  one-cycle pulse after each stop bit completes.

Behaviour:
- Reset (reset_n low at a posedge):
  - Next state is IDLE; tx_serial=1, fifo_read_n=1, busy=0, frame_done=0.
  - Baud counter, bit index and shift register are cleared.
  - Reset mid-frame abandons the byte, which is lost; tx_serial returns high on that edge.
- Outputs: every output is registered or decoded directly from the state register (Moore); no combinational path from inputs to outputs.
- FSM states: IDLE, FETCH, WAIT, START, DATA, PARITY (only with the optional feature), STOP.
  - IDLE -> FETCH when tx_enable=1 and fifo_empty=0; otherwise stay in IDLE.
  - FETCH: fifo_read_n=0 for exactly this one cycle. The FIFO pops on the edge leaving FETCH. Always -> WAIT.
  - WAIT: fifo_data is valid. The shift register captures fifo_data on the edge leaving WAIT. Always -> START.
  - START: tx_serial=0 for CLKS_PER_BIT cycles, then -> DATA with bit index 0.
  - DATA: tx_serial=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit. After bit DATA_WIDTH-1 -> PARITY (feature on) or STOP.
  - PARITY: see Optional Feature.
  - STOP: tx_serial=1 for CLKS_PER_BIT cycles. At the end, frame_done pulses high for the next cycle. Next state is FETCH if tx_enable=1 and fifo_empty=0 (sampled on that edge), else IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 within each bit state.
  - Wraps to 0 on a bit boundary.
  - Held at 0 in IDLE, FETCH and WAIT.
- Back-to-back timing: gap between the end of one stop bit and the next start bit is exactly 2 cycles (FETCH, WAIT) of tx_serial=1.
- fifo_read_n is never low while fifo_empty was 1 at the FETCH decision edge. No pop occurs after FIFO underflow.
- tx_enable deassertion mid-frame has no effect until the STOP decision.
- Frame length is (DATA_WIDTH+2)*CLKS_PER_BIT cycles, plus CLKS_PER_BIT when parity is enabled.

Optional Feature:
- Macro: SFIFO_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP.
  - tx_serial = XOR of the captured byte (even parity: total ones including the parity bit is even) for CLKS_PER_BIT cycles.
  - Parity is computed from the byte latched in WAIT, not from the shifted register.
- Undefined: PARITY state and its logic are absent; DATA -> STOP directly.

Test Plan:
- Reset and idle: reset_n=0 for 3 cycles with fifo_empty=0 and tx_enable=1 -> tx_serial=1, fifo_read_n=1, busy=0 throughout. Release reset -> fifo_read_n low exactly 1 cycle, 1 cycle after release.
- Single byte, CLKS_PER_BIT=4, FIFO holds 0xA5, no parity:
  - tx_serial = 0 x4, then 1,0,1,0,0,1,0,1 (4 cycles each), then 1 x4.
  - frame_done pulses once, 40 cycles after START entry.
  - Exactly one pop.
- Parity build, same stimulus:
  - Parity slot carries 0 for 0xA5.
  - For 0x07 the parity slot carries 1.
  - Frame length is 44 cycles.
- Back-to-back: FIFO holds 0x01,0x80,0xFF with tx_enable=1 -> three frames, each separated by exactly 2 high cycles after the stop bit; 3 pops total; then IDLE with busy=0.
- Empty/enable gating:
  - fifo_empty=1 with tx_enable=1 -> no pops, tx_serial stays 1.
  - tx_enable dropped mid-frame with FIFO non-empty -> current frame completes, then IDLE, no further pop.
- Reset mid-frame: assert reset_n=0 during DATA bit 3 -> next cycle tx_serial=1, busy=0. After release with FIFO non-empty, a new frame starts with the next FIFO byte, not the abandoned one.
